// File: rtl/id_hazard_scoreboard_if.sv
// id_hazard_scoreboard_if
//   Bundles the ID-stage request, WB retire and scoreboard status signals.
//   master : pipeline side (drives ID/WB inputs, observes stall/issue/status)
//   slave  : scoreboard side
//   ID   : id_valid, id_uses_ra, id_uses_rb, id_ra_idx, id_rb_idx,
//          id_reg_wr, id_dest_idx, flush
//   WB   : wb_valid, wb_reg_wr, wb_dest_idx
//   out  : stall, issue, busy_mask, inflight_cnt, sb_err, watchdog_err
interface id_hazard_scoreboard_if;
    logic        id_valid;
    logic        id_uses_ra;
    logic        id_uses_rb;
    logic [4:0]  id_ra_idx;
    logic [4:0]  id_rb_idx;
    logic        id_reg_wr;
    logic [4:0]  id_dest_idx;
    logic        flush;
    logic        wb_valid;
    logic        wb_reg_wr;
    logic [4:0]  wb_dest_idx;
    logic        stall;
    logic        issue;
    logic [31:0] busy_mask;
    logic [6:0]  inflight_cnt;
    logic        sb_err;
    logic        watchdog_err;

    modport master (
        output id_valid, id_uses_ra, id_uses_rb, id_ra_idx, id_rb_idx,
               id_reg_wr, id_dest_idx, flush, wb_valid, wb_reg_wr, wb_dest_idx,
        input  stall, issue, busy_mask, inflight_cnt, sb_err, watchdog_err
    );

    modport slave (
        input  id_valid, id_uses_ra, id_uses_rb, id_ra_idx, id_rb_idx,
               id_reg_wr, id_dest_idx, flush, wb_valid, wb_reg_wr, wb_dest_idx,
        output stall, issue, busy_mask, inflight_cnt, sb_err, watchdog_err
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
//   Per-register pending-write scoreboard for the ID stage. Counts writes from
//   issue to WB retire and produces the ID stall / issue strobes.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-low
//   sb   : scoreboard interface (slave side), see id_hazard_scoreboard_if
module id_hazard_scoreboard #(
    parameter int CNT_W         = 2,
    parameter int STALL_TIMEOUT = 16,
    parameter bit WB_BYPASS     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    id_hazard_scoreboard_if.slave   sb
);
    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam int               SC_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STALL_TIMEOUT);

    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic [31:0]      busy_q, busy_d;
    logic [6:0]       infl_q, infl_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic             sb_err_q, sb_err_d;
    logic             wd_q, wd_d;

    logic             dec, inc, byp_a, byp_b, hit_a, hit_b, waw_full;
    logic             stall, issue;
    logic [CNT_W-1:0] pend_ra, pend_rb, pend_rd, pend_wd;

    assign pend_ra = pend_q[sb.id_ra_idx];
    assign pend_rb = pend_q[sb.id_rb_idx];
    assign pend_rd = pend_q[sb.id_dest_idx];
    assign pend_wd = pend_q[sb.wb_dest_idx];

    assign dec = sb.wb_valid && sb.wb_reg_wr && (sb.wb_dest_idx != 5'd0);

    // With a write-through regfile, the last outstanding write retiring this
    // cycle already satisfies the read.
    assign byp_a = WB_BYPASS && dec && (sb.wb_dest_idx == sb.id_ra_idx) && (pend_ra == CNT_W'(1));
    assign byp_b = WB_BYPASS && dec && (sb.wb_dest_idx == sb.id_rb_idx) && (pend_rb == CNT_W'(1));

    assign hit_a = sb.id_uses_ra && (sb.id_ra_idx != 5'd0) && (pend_ra != '0) && !byp_a;
    assign hit_b = sb.id_uses_rb && (sb.id_rb_idx != 5'd0) && (pend_rb != '0) && !byp_b;

    // A saturated counter may still accept an issue if one retires this cycle.
    assign waw_full = sb.id_reg_wr && (sb.id_dest_idx != 5'd0) && (pend_rd == MAX)
                      && !(dec && (sb.wb_dest_idx == sb.id_dest_idx));

    // rst gating keeps both strobes low while held in reset.
    assign stall = rst && sb.id_valid && !sb.flush && (hit_a || hit_b || waw_full);
    assign issue = rst && sb.id_valid && !sb.flush && !stall;
    assign inc   = issue && sb.id_reg_wr && (sb.id_dest_idx != 5'd0);

    always_comb begin
        busy_d   = '0;
        infl_d   = '0;
        sb_err_d = sb_err_q || (dec && (pend_wd == '0));
        for (int r = 0; r < 32; r++) begin
            pend_d[r] = pend_q[r];
            if (r == 0) begin
                pend_d[r] = '0;
            end else if (inc && (sb.id_dest_idx == 5'(r)) &&
                         !(dec && (sb.wb_dest_idx == 5'(r)))) begin
                pend_d[r] = pend_q[r] + CNT_W'(1);
            end else if (dec && (sb.wb_dest_idx == 5'(r)) &&
                         !(inc && (sb.id_dest_idx == 5'(r))) && (pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] - CNT_W'(1);
            end
            busy_d[r] = (pend_d[r] != '0);
            infl_d    = infl_d + 7'(pend_d[r]);
        end
        if (!stall)
            sc_d = '0;
        else if (sc_q == SC_MAX)
            sc_d = sc_q;
        else
            sc_d = sc_q + SC_W'(1);
        wd_d = wd_q || (sc_d == SC_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) pend_q[r] <= '0;
            busy_q   <= '0;
            infl_q   <= '0;
            sc_q     <= '0;
            sb_err_q <= 1'b0;
            wd_q     <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
            busy_q   <= busy_d;
            infl_q   <= infl_d;
            sc_q     <= sc_d;
            sb_err_q <= sb_err_d;
            wd_q     <= wd_d;
        end
    end

    assign sb.stall        = stall;
    assign sb.issue        = issue;
    assign sb.busy_mask    = busy_q;
    assign sb.inflight_cnt = infl_q;
    assign sb.sb_err       = sb_err_q;
    assign sb.watchdog_err = wd_q;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;
    logic clk;
    logic rst;
    id_hazard_scoreboard_if bus ();

    id_hazard_scoreboard #(.CNT_W(2), .STALL_TIMEOUT(16), .WB_BYPASS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic        ura;
        logic [4:0]  ra;
        logic        urb;
        logic [4:0]  rb;
        logic        wr;
        logic [4:0]  rd;
        logic        fl;
        logic        wbv;
        logic [4:0]  wd;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_busy;
        logic [6:0]  e_infl;
        logic        e_sb;
        logic        e_wd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl [$];

    localparam logic [31:0] B3  = 32'h0000_0008;
    localparam logic [31:0] B5  = 32'h0000_0020;
    localparam logic [31:0] B7  = 32'h0000_0080;
    localparam logic [31:0] B10 = 32'h0000_0400;

    function automatic vec_t mk(logic r, logic v, logic ura, logic [4:0] ra, logic urb, logic [4:0] rb,
                                logic wr, logic [4:0] rd, logic fl, logic wbv, logic [4:0] wd,
                                logic es, logic ei, logic [31:0] eb, logic [6:0] en, logic esb, logic ewd);
        vec_t t;
        t.rst = r; t.v = v; t.ura = ura; t.ra = ra; t.urb = urb; t.rb = rb;
        t.wr = wr; t.rd = rd; t.fl = fl; t.wbv = wbv; t.wd = wd;
        t.e_stall = es; t.e_issue = ei; t.e_busy = eb; t.e_infl = en; t.e_sb = esb; t.e_wd = ewd;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle: check combinational strobes before the edge, registered
    // state just after it.
    task automatic apply(vec_t t, int idx);
        rst             = t.rst;
        bus.id_valid    = t.v;
        bus.id_uses_ra  = t.ura;
        bus.id_ra_idx   = t.ra;
        bus.id_uses_rb  = t.urb;
        bus.id_rb_idx   = t.rb;
        bus.id_reg_wr   = t.wr;
        bus.id_dest_idx = t.rd;
        bus.flush       = t.fl;
        bus.wb_valid    = t.wbv;
        bus.wb_reg_wr   = t.wbv;
        bus.wb_dest_idx = t.wd;
        #2;
        chk("stall", idx, 32'(bus.stall), 32'(t.e_stall));
        chk("issue", idx, 32'(bus.issue), 32'(t.e_issue));
        @(posedge clk);
        #1;
        chk("busy_mask", idx, bus.busy_mask, t.e_busy);
        chk("inflight_cnt", idx, 32'(bus.inflight_cnt), 32'(t.e_infl));
        chk("sb_err", idx, 32'(bus.sb_err), 32'(t.e_sb));
        chk("watchdog_err", idx, 32'(bus.watchdog_err), 32'(t.e_wd));
    endtask

    initial begin
        // reset with a would-be hazard present
        tbl.push_back(mk(0,1,1,5,0,0,1,5,0,0,0, 0,0,32'h0,0,0,0));
        tbl.push_back(mk(0,1,1,5,0,0,1,5,0,0,0, 0,0,32'h0,0,0,0));
        // RAW on x5, bypassed retire in cycle 4
        tbl.push_back(mk(1,1,0,0,0,0,1,5,0,0,0, 0,1,B5,1,0,0));
        tbl.push_back(mk(1,1,1,5,0,0,0,0,0,0,0, 1,0,B5,1,0,0));
        tbl.push_back(mk(1,1,1,5,0,0,0,0,0,0,0, 1,0,B5,1,0,0));
        tbl.push_back(mk(1,1,1,5,0,0,0,0,0,0,0, 1,0,B5,1,0,0));
        tbl.push_back(mk(1,1,1,5,0,0,0,0,0,1,5, 0,1,32'h0,0,0,0));
        // x0 never tracked
        tbl.push_back(mk(1,1,1,0,1,0,1,0,0,0,0, 0,1,32'h0,0,0,0));
        // fill x7 to MAX, WAW stall, same-register inc+dec
        tbl.push_back(mk(1,1,0,0,0,0,1,7,0,0,0, 0,1,B7,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,0,0,0, 0,1,B7,2,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,0,0,0, 0,1,B7,3,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,0,0,0, 1,0,B7,3,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,0,1,7, 0,1,B7,3,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,7, 0,0,B7,2,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,7, 0,0,B7,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,0,1,7, 0,1,B7,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,7, 0,0,32'h0,0,0,0));
        // flush priority
        tbl.push_back(mk(1,1,0,0,0,0,1,3,1,0,0, 0,0,32'h0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,3,0,0,0, 0,1,B3,1,0,0));
        tbl.push_back(mk(1,1,1,3,0,0,1,4,1,0,0, 0,0,B3,1,0,0));
        // retire on idle register -> sb_err
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,9, 0,0,B3,1,1,0));
        // rb hazard, bypassed
        tbl.push_back(mk(1,1,0,0,1,3,0,0,0,0,0, 1,0,B3,1,1,0));
        tbl.push_back(mk(1,1,0,0,1,3,0,0,0,1,3, 0,1,32'h0,0,1,0));
        // no bypass while pend == 2
        tbl.push_back(mk(1,1,0,0,0,0,1,3,0,0,0, 0,1,B3,1,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,3,0,0,0, 0,1,B3,2,1,0));
        tbl.push_back(mk(1,1,1,3,0,0,0,0,0,1,3, 1,0,B3,1,1,0));
        tbl.push_back(mk(1,1,1,3,0,0,0,0,0,1,3, 0,1,32'h0,0,1,0));

        foreach (tbl[i]) apply(tbl[i], i);

        // watchdog: stall counter clears on a gap, then trips on 16th edge
        apply(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,0), 100);
        apply(mk(1,1,0,0,0,0,1,10,0,0,0, 0,1,B10,1,0,0), 101);
        for (int i = 0; i < 10; i++)
            apply(mk(1,1,1,10,0,0,0,0,0,0,0, 1,0,B10,1,0,0), 110 + i);
        apply(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,B10,1,0,0), 120);
        for (int i = 0; i < 16; i++)
            apply(mk(1,1,1,10,0,0,0,0,0,0,0, 1,0,B10,1,0,logic'(i == 15)), 130 + i);
        apply(mk(1,1,1,10,0,0,0,0,0,1,10, 0,1,32'h0,0,0,1), 150);
        apply(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,1), 151);
        apply(mk(0,1,1,10,0,0,1,10,0,0,0, 0,0,32'h0,0,0,0), 152);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
